// File: rtl/scnn_cartesian_scheduler_pkg.sv
// Shared constants, FSM state type, lane request record and small
// index helpers for the SCNN Cartesian-product scheduler.
package scnn_pkg;

    localparam int NUM_PE = 4;
    localparam int ACT_W  = 16;
    localparam int ACC_W  = 32;
    localparam int IN_DIM = 8;
    localparam int K_DIM  = 3;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    typedef struct packed {
        logic             valid;
        logic             in_range;
        logic [5:0]       addr;
        logic [ACC_W-1:0] prod;
    } lane_req_t;

    // Lowest set bit of a 16-bit mask; 0 when the mask is empty.
    function automatic logic [3:0] lsb_idx(input logic [15:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--)
            if (m[i]) idx = 4'(i);
        return idx;
    endfunction

    // Filter row / column of a row-major 3x3 weight index.
    function automatic logic [1:0] k_row(input logic [3:0] k);
        return (k >= 4'd6) ? 2'd2 : (k >= 4'd3) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [1:0] k_col(input logic [3:0] k);
        logic [3:0] r;
        r = k - 4'(3 * k_row(k));
        return r[1:0];
    endfunction

endpackage

// File: rtl/scnn_cartesian_scheduler_lane_seq.sv
// One PE lane: walks non-zero weights (outer) x non-zero activations
// (inner) of its two-row slice and presents one product per cycle.
module scnn_lane_seq
    import scnn_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic                              grant,
    input  logic [15:0][ACT_W-1:0]            lane_acts,
    input  logic [K_DIM*K_DIM-1:0][ACT_W-1:0] wts,
    output lane_req_t                         req,
    output logic                              exhausted
);

    logic [15:0][ACT_W-1:0]            act_q;
    logic [K_DIM*K_DIM-1:0][ACT_W-1:0] wt_q;
    logic [K_DIM*K_DIM-1:0]            wmask, wnz;
    logic [15:0]                       amask, anz, anz_new;
    logic [3:0]                        k, a;
    logic [4:0]                        ar, row, col;

    // Non-zero masks of the incoming operands, built while loading.
    always_comb begin
        anz_new = '0;
        wnz     = '0;
        for (int i = 0; i < 16; i++) anz_new[i] = |lane_acts[i];
        for (int i = 0; i < K_DIM*K_DIM; i++) wnz[i] = |wts[i];
    end

    // Current pair, output coordinate (same padding) and product.
    always_comb begin
        k   = lsb_idx({7'b0, wmask});
        a   = lsb_idx(amask);
        ar  = 5'(2 * LANE) + {4'b0, a[3]};
        // Negative coordinates wrap to >= 8, so one compare covers both ends.
        row = ar + 5'd1 - {3'b0, k_row(k)};
        col = {2'b0, a[2:0]} + 5'd1 - {3'b0, k_col(k)};
        exhausted    = (wmask == '0);
        req.valid    = !exhausted;
        req.in_range = (row < 5'd8) && (col < 5'd8);
        req.addr     = {row[2:0], col[2:0]};
        req.prod     = ACC_W'(act_q[a]) * ACC_W'(wt_q[k]);
    end

    // Operand snapshot; only meaningful after a load.
    always_ff @(posedge clk) begin
        if (load) begin
            act_q <= lane_acts;
            wt_q  <= wts;
        end
    end

    // Remaining-mask walk: clear the consumed activation, roll to the next
    // weight when the last activation of the current one is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wmask <= '0;
            amask <= '0;
            anz   <= '0;
        end else if (load) begin
            anz   <= anz_new;
            amask <= anz_new;
            wmask <= (|anz_new) ? wnz : '0;
        end else if (grant && !exhausted) begin
            if ((amask & (amask - 16'd1)) == '0) begin
                wmask <= wmask & (wmask - 9'd1);
                amask <= anz;
            end else begin
                amask <= amask & (amask - 16'd1);
            end
        end
    end

endmodule

// File: rtl/scnn_cartesian_scheduler.sv
// Top: FSM, lane array, lowest-lane-wins collision arbitration and the
// shared 64-entry accumulator that drives the outputs directly.
module scnn_cartesian_scheduler
    import scnn_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [63:0][ACT_W-1:0]            input_acts,
    input  logic [7:0]                        input_dim,
    input  logic [K_DIM*K_DIM-1:0][ACT_W-1:0] weights,
    input  logic [3:0]                        weight_dim,
    output logic [63:0][ACC_W-1:0]            outputs,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    state_t              state;
    lane_req_t           req [NUM_PE];
    logic [NUM_PE-1:0]   exh, win, grant;
    logic                dims_ok, lane_load;

    assign dims_ok   = (input_dim == 8'(IN_DIM)) && (weight_dim == 4'(K_DIM));
    // A rejected start still passes through LOAD but must not touch state.
    assign lane_load = (state == LOAD) && !err;

    for (genvar p = 0; p < NUM_PE; p++) begin : g_lane
        scnn_lane_seq #(.LANE(p)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (lane_load),
            .grant     (grant[p]),
            .lane_acts (input_acts[p*16 +: 16]),
            .wts       (weights),
            .req       (req[p]),
            .exhausted (exh[p])
        );
    end

    // Lowest lane wins a shared address; discarded products always advance.
    always_comb begin
        win   = '0;
        grant = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            win[p] = (state == RUN) && req[p].valid && req[p].in_range;
            for (int q = 0; q < p; q++)
                if (req[q].valid && req[q].in_range && req[q].addr == req[p].addr)
                    win[p] = 1'b0;
            grant[p] = (state == RUN) && req[p].valid && (!req[p].in_range || win[p]);
        end
    end

    // Sequencer plus accumulator updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            outputs <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        err   <= !dims_ok;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (err) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        outputs <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int p = 0; p < NUM_PE; p++)
                        if (win[p])
                            outputs[req[p].addr] <= outputs[req[p].addr] + req[p].prod;
                    if (&exh) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scnn_cartesian_scheduler.sv
// Directed bench for the SCNN Cartesian scheduler with hand-computed results.
module tb_scnn_cartesian_scheduler;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [63:0][15:0] input_acts = '0;
    logic [7:0]        input_dim = 8'd8;
    logic [8:0][15:0]  weights = '0;
    logic [3:0]        weight_dim = 4'd3;
    logic [63:0][31:0] outputs;
    logic              busy, done, err;

    int ncmp = 0;
    int nerr = 0;
    logic [31:0] exp_o [64];

    scnn_cartesian_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .input_acts (input_acts),
        .input_dim  (input_dim),
        .weights    (weights),
        .weight_dim (weight_dim),
        .outputs    (outputs),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        for (int i = 0; i < 64; i++)
            chk($sformatf("%s_out%0d", tag, i), outputs[i], exp_o[i]);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) exp_o[i] = '0;
    endtask

    // Pulse start, count edges until done is visible, check latency and err.
    // done sampled just after edge n means the edge n+1 sees it high.
    // With poke set, a second start plus new activations arrive mid-run.
    task automatic run(input string tag, input int exp_lat, input logic exp_err, input bit poke);
        int lat;
        bit seen;
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk) #1;
            lat++;
            if (poke && lat == 2) begin
                start = 1'b1;
                for (int i = 0; i < 64; i++) input_acts[i] = 16'($urandom);
            end
            if (poke && lat == 3) start = 1'b0;
            if (done) seen = 1'b1;
        end
        chk({tag, "_lat"}, 32'(lat + 1), 32'(exp_lat));
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd1);
        @(posedge clk) #1;
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        bit done_seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk) #1;
        clear_exp();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err",  {31'b0, err},  32'd0);
        check_outs("rst");

        // Single activation through five weights
        input_acts = '0; input_acts[27] = 16'd2;
        weights = '0;
        weights[0] = 16'd2; weights[1] = 16'd5; weights[2] = 16'd1;
        weights[4] = 16'd2; weights[7] = 16'd3;
        run("single", 8, 1'b0, 1'b0);
        clear_exp();
        exp_o[36] = 4; exp_o[35] = 10; exp_o[34] = 2; exp_o[27] = 4; exp_o[19] = 6;
        check_outs("single");

        // Lane1/lane2 collision on out[27]
        input_acts = '0;
        input_acts[16] = 16'd1; input_acts[19] = 16'd2; input_acts[35] = 16'd1;
        weights = '0; weights[1] = 16'd5; weights[7] = 16'd3;
        run("collide", 7, 1'b0, 1'b0);
        clear_exp();
        exp_o[24] = 5; exp_o[27] = 13; exp_o[43] = 5; exp_o[8] = 3; exp_o[11] = 6;
        check_outs("collide");

        // Corner activation: five of nine products discarded
        input_acts = '0; input_acts[0] = 16'd7;
        for (int i = 0; i < 9; i++) weights[i] = 16'd1;
        run("boundary", 12, 1'b0, 1'b0);
        clear_exp();
        exp_o[0] = 7; exp_o[1] = 7; exp_o[8] = 7; exp_o[9] = 7;
        check_outs("boundary");

        // Unsupported plane edge: err, fast done, outputs keep boundary result
        input_dim = 8'd16;
        for (int i = 0; i < 64; i++) input_acts[i] = 16'($urandom);
        run("baddim", 2, 1'b1, 1'b0);
        check_outs("baddim");
        input_dim = 8'd8;

        // All-zero weights: outputs cleared, err cleared
        weights = '0;
        run("zerow", 3, 1'b0, 1'b0);
        clear_exp();
        check_outs("zerow");

        // Start while busy is ignored and the snapshot is kept
        input_acts = '0; input_acts[27] = 16'd2;
        weights = '0;
        weights[0] = 16'd2; weights[1] = 16'd5; weights[2] = 16'd1;
        weights[4] = 16'd2; weights[7] = 16'd3;
        run("rebusy", 8, 1'b0, 1'b1);
        clear_exp();
        exp_o[36] = 4; exp_o[35] = 10; exp_o[34] = 2; exp_o[27] = 4; exp_o[19] = 6;
        check_outs("rebusy");

        // Reset during RUN aborts with no done pulse
        input_acts = '0;
        input_acts[16] = 16'd1; input_acts[19] = 16'd2; input_acts[35] = 16'd1;
        weights = '0; weights[1] = 16'd5; weights[7] = 16'd3;
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        clear_exp();
        check_outs("midrst");
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (12) begin
            @(posedge clk) #1;
            if (done) done_seen = 1'b1;
        end
        chk("midrst_no_done", {31'b0, done_seen}, 32'd0);
        check_outs("midrst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/scnn_cartesian_scheduler.md
Name: scnn_cartesian_scheduler

Overview:
- Sequences the 4-PE sparse convolution datapath for one 8x8 activation plane and one 3x3 filter.
- Splits the plane into 4 row-slices, one per PE lane. Lane p owns rows 2p..2p+1, i.e. activation indices 16p..16p+15.
- Each lane walks the Cartesian product of non-zero weights x non-zero activations in its slice.
- A shared 64-entry accumulator is arbitrated across lanes; on an address collision the lowest lane index wins.

Parameters:
- NUM_PE, 4, number of PE lanes / row-slices.
- ACT_W, 16, activation and weight width (unsigned).
- ACC_W, 32, accumulator / output width.
- IN_DIM, 8, supported input plane edge.
- K_DIM, 3, supported filter edge.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- input_acts  in  [63:0][15:0]  row-major activations, index = row*8+col
- input_dim  in  8  plane edge; must equal 8
- weights  in  [8:0][15:0]  row-major filter, index = kr*3+kc
- weight_dim  in  4  filter edge; must equal 3
- outputs  out  [63:0][31:0]  accumulated outputs, row-major
- busy  out  1  high from LOAD through DONE
- done  out  1  one-cycle completion pulse
- err  out  1  high when the last start had unsupported dims; cleared by the next start

Behaviour:
- Reset:
  - state=IDLE; outputs, busy, done and err all 0.
  - Reset mid-run aborts immediately: accumulator cleared, no done pulse.
- FSM states: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 with dims 8/3: go to LOAD and clear err.
  - start=1 with other dims: set err, go to DONE, outputs left untouched.
- LOAD (1 cycle):
  - Snapshot input_acts and weights into internal registers.
  - Build a 9-bit weight non-zero mask and per-lane 16-bit activation non-zero masks.
  - Clear all 64 accumulators.
- RUN:
  - Each lane loops weights outer and activations inner, both in ascending index order.
  - Zero operands are skipped in 0 cycles using a priority encoder on the remaining-mask.
  - Each lane presents at most one product per cycle.
  - Output coordinate = (ar-kr+1, ac-kc+1), i.e. same padding. If row or col falls outside 0..7, the product is discarded but the cycle is still consumed.
  - Product is a 16x16 unsigned multiply, zero-extended to 32 bits. Accumulation wraps mod 2^32.
- Arbitration:
  - All in-range lanes with distinct target addresses write in the same cycle.
  - On the same target address, the lowest lane index writes; the others hold their (k,a) pair and retry next cycle.
  - Discarded (out-of-range) products never collide.
- A lane is exhausted when its weight and activation masks are spent. RUN -> DONE in the cycle after all lanes are exhausted.
- DONE (1 cycle): done=1, busy=1, then IDLE. outputs hold until the next LOAD.
- Latency: done is high exactly 3 + max over lanes of (products + stall cycles) cycles after the start-sampling edge.
- Edge cases:
  - All-zero weights or all-zero activations: done at start+3, outputs all 0.
  - start while busy: ignored.

Decomposition:
- Package scnn_pkg holds:
  - ACT_W, ACC_W, IN_DIM, K_DIM and NUM_PE constants.
  - The state_t enum {IDLE, LOAD, RUN, DONE}.
  - The lane request struct {valid, in_range, addr[5:0], prod[31:0]}.
- Sub-module scnn_lane_seq is instantiated NUM_PE times.
  - Contents: mask registers, priority encoders, coordinate/range computation and the multiply.
  - Inputs: grant, load.
  - Outputs: request struct, exhausted.
- Collision arbitration and the accumulator array stay in the top module.

Test Plan:
- Single activation: act[27]=2, weights w0=2, w1=5, w2=1, w4=2, w7=3 (others 0) -> out[36]=4, out[35]=10, out[34]=2, out[27]=4, out[19]=6, all other outputs 0; done 8 cycles after start.
- Collision: act[16]=1, act[19]=2, act[35]=1, weights w1=5, w7=3 only.
  - Lane1 and lane2 both target out[27] in step 2; lane2 stalls 1 cycle.
  - Expected: out[24]=5, out[27]=13, out[43]=5, out[8]=3, out[11]=6; done 7 cycles after start.
- Boundary discard: act[0]=7, all 9 weights=1 -> out[0]=out[1]=out[8]=out[9]=7, all others 0; 9 cycles consumed, done at start+12.
- Degenerate inputs:
  - All weights 0 with random activations -> outputs 0, done at start+3.
  - input_dim=16 -> err=1 and done at start+2, outputs unchanged from the previous run.
- Reset and re-entry:
  - rst pulsed during RUN -> busy=0 and outputs=0 next cycle, no done.
  - start pulsed while busy -> ignored; the run completes with the original values.
